// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader
//
// Pop-side consumer for fifo_async, clocked in the pop domain. Waits until the
// FIFO holds at least one full burst and, on request, drains exactly BURST_LEN
// words onto a registered valid/ready stream, flagging the final word with
// out_last. Downstream block-transfer logic relies on never seeing a partial
// block, so a burst is only started once all of its words are already queued.
//
// Ports:
//   clk            pop-domain clock (FIFO pop_clk)
//   rst_n          asynchronous active-low reset
//   fifo_pop       pop strobe to the FIFO
//   fifo_pop_data  FIFO head word (first-word-fall-through)
//   fifo_pop_empty FIFO empty flag
//   fifo_pop_count FIFO occupancy
//   start          burst request, honoured only when idle and burst_ready
//   burst_ready    registered: FIFO held at least BURST_LEN words last cycle
//   busy           burst in progress
//   out_valid      out_data / out_last are valid
//   out_data       output word
//   out_last       final word of the burst
//   out_ready      downstream accepts the current word
//   burst_done     one-cycle pulse the cycle after the last handshake
module fifo_burst_reader #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned BURST_LEN  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  fifo_pop,
  input  logic [DATA_WIDTH-1:0] fifo_pop_data,
  input  logic                  fifo_pop_empty,
  input  logic [ADDR_WIDTH:0]   fifo_pop_count,
  input  logic                  start,
  output logic                  burst_ready,
  output logic                  busy,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  burst_done
);

  localparam int unsigned RemW = $clog2(BURST_LEN + 1);
  localparam int unsigned CntW = ADDR_WIDTH + 1;

  localparam logic [RemW-1:0] RemInit   = RemW'(BURST_LEN);
  localparam logic [RemW-1:0] RemOne    = RemW'(1);
  localparam logic [CntW-1:0] CntThresh = CntW'(BURST_LEN);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StBurst = 2'd1;
  localparam logic [1:0] StFlush = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [RemW-1:0]       remaining_q, remaining_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_last_q, out_last_d;
  logic                  burst_done_q, burst_done_d;
  logic                  burst_ready_q;

  logic load;
  logic handshake;
  logic pop;

  always_comb begin
    handshake = out_valid_q & out_ready;
    // Output register can take a new word if empty or emptying this cycle.
    load      = ~out_valid_q | handshake;
    // Popping is gated by load, so a stalled consumer never causes an over-read.
    pop       = (state_q == StBurst) & load & ~fifo_pop_empty & (remaining_q != '0);
  end

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    burst_done_d = 1'b0;

    if (pop) begin
      out_valid_d = 1'b1;
      out_data_d  = fifo_pop_data;
      out_last_d  = (remaining_q == RemOne);
      remaining_d = remaining_q - RemOne;
    end else if (handshake) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    case (state_q)
      StIdle: begin
        if (start && burst_ready_q) begin
          state_d     = StBurst;
          remaining_d = RemInit;
        end
      end
      StBurst: begin
        if ((pop && remaining_q == RemOne) || remaining_q == '0) begin
          state_d = StFlush;
        end
      end
      StFlush: begin
        if (handshake && out_last_q) begin
          state_d      = StIdle;
          burst_done_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      remaining_q   <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_last_q    <= 1'b0;
      burst_done_q  <= 1'b0;
      burst_ready_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      remaining_q   <= remaining_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_last_q    <= out_last_d;
      burst_done_q  <= burst_done_d;
      // One cycle stale; safe because only this block drains the FIFO.
      burst_ready_q <= (fifo_pop_count >= CntThresh);
    end
  end

  always_comb begin
    fifo_pop    = pop;
    burst_ready = burst_ready_q;
    busy        = (state_q != StIdle);
    out_valid   = out_valid_q;
    out_data    = out_data_q;
    out_last    = out_last_q;
    burst_done  = burst_done_q;
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
module tb_fifo_burst_reader;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 4;
  localparam int unsigned BL = 8;
  localparam int unsigned HN = 4096;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fifo_pop;
  logic [DW-1:0] fifo_pop_data;
  logic          fifo_pop_empty;
  logic [AW:0]   fifo_pop_count;
  logic          start;
  logic          burst_ready;
  logic          busy;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          out_ready;
  logic          burst_done;

  always #5 clk = ~clk;

  fifo_burst_reader #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .BURST_LEN (BL)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fifo_pop      (fifo_pop),
    .fifo_pop_data (fifo_pop_data),
    .fifo_pop_empty(fifo_pop_empty),
    .fifo_pop_count(fifo_pop_count),
    .start         (start),
    .burst_ready   (burst_ready),
    .busy          (busy),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_last      (out_last),
    .out_ready     (out_ready),
    .burst_done    (burst_done)
  );

  // FIFO model: every pushed word kept by ordinal; rd/wr are absolute ordinals.
  logic [DW-1:0] hist [HN];
  int unsigned   wr = 0;
  int unsigned   rd = 0;
  bit            flush_req = 1'b0;

  assign fifo_pop_empty = (wr == rd);
  assign fifo_pop_count = (AW + 1)'(wr - rd);
  assign fifo_pop_data  = hist[rd[11:0]];

  always @(posedge clk) begin
    if (flush_req) rd <= wr;
    else if (fifo_pop && wr != rd) rd <= rd + 1;
  end

  // Reference model of the stream contract.
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned popped, delivered, n_out, owed, bidx, cnt_prev;
  bit          m_idle, done_pend, hold;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  logic          s_valid, s_last, s_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    n_out = rd; popped = 0; delivered = 0; owed = 0; bidx = 0; cnt_prev = 0;
    m_idle = 1'b1; done_pend = 1'b0; hold = 1'b0;
  endtask

  // One clock: sample and check at negedge, return 1 time unit after posedge.
  task automatic step();
    bit hs, hs_last, acc, br_exp, last_exp;
    @(negedge clk);
    s_valid = out_valid; s_last = out_last; s_done = burst_done;
    if (!rst_n) begin
      chk("reset_ctrl", 32'({fifo_pop, burst_ready, busy, out_valid, out_last, burst_done}), 0);
      chk("reset_data", 32'(out_data), 0);
    end else begin
      br_exp = (cnt_prev >= BL);
      chk("burst_ready", 32'(burst_ready), 32'(br_exp));
      chk("busy", 32'(busy), 32'(!m_idle));
      chk("burst_done", 32'(burst_done), 32'(done_pend));
      chk("out_valid", 32'(out_valid), 32'(popped > delivered));
      if (hold) begin
        chk("hold_valid", 32'(out_valid), 1);
        chk("hold_data", 32'(out_data), 32'(prev_data));
        chk("hold_last", 32'(out_last), 32'(prev_last));
      end
      if (fifo_pop) begin
        chk("pop_when_empty", 32'(fifo_pop_empty), 0);
        chk("pop_beyond_burst", 32'(owed != 0), 1);
        if (owed != 0) owed--;
        popped++;
      end
      hs = out_valid && out_ready;
      hs_last = 1'b0;
      if (hs) begin
        last_exp = (bidx == BL - 1);
        chk("out_data", 32'(out_data), 32'(hist[n_out[11:0]]));
        chk("out_last", 32'(out_last), 32'(last_exp));
        n_out++; delivered++; bidx++;
        hs_last = last_exp;
      end
      acc = m_idle && start && br_exp;
      if (hs_last) begin
        chk("pops_per_burst", 32'(owed), 0);
        m_idle = 1'b1;
      end
      if (acc) begin
        m_idle = 1'b0; owed = BL; bidx = 0;
      end
      done_pend = hs_last;
      hold      = out_valid && !out_ready;
      prev_data = out_data;
      prev_last = out_last;
      cnt_prev  = 32'(fifo_pop_count);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d);
    hist[wr[11:0]] = d;
    wr++;
  endtask

  task automatic flush();
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    n_out = wr;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (burst_done) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    chk("done_timeout", 32'(seen), 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("async_reset_ctrl", 32'({fifo_pop, busy, out_valid, out_last, burst_done}), 0);
    chk("async_reset_data", 32'(out_data), 0);
    step();
    step();
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    int unsigned preload;
    logic [3:0]  ready_pat;
    bit          exp_accept;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n0, c0;
    logic [3:0] pat;

    vecs[0] = '{preload: 7,  ready_pat: 4'b1111, exp_accept: 1'b0};
    vecs[1] = '{preload: 8,  ready_pat: 4'b1111, exp_accept: 1'b1};
    vecs[2] = '{preload: 9,  ready_pat: 4'b1010, exp_accept: 1'b1};
    vecs[3] = '{preload: 16, ready_pat: 4'b0011, exp_accept: 1'b1};
    vecs[4] = '{preload: 15, ready_pat: 4'b1000, exp_accept: 1'b1};
    vecs[5] = '{preload: 0,  ready_pat: 4'b1111, exp_accept: 1'b0};
    vecs[6] = '{preload: 8,  ready_pat: 4'b0001, exp_accept: 1'b1};

    // Reset with start held high and an empty FIFO.
    rst_n = 1'b0; start = 1'b1; out_ready = 1'b0;
    model_reset();
    repeat (3) step();
    rst_n = 1'b1;
    repeat (4) step();
    chk("start_ignored_busy", 32'(busy), 0);
    start = 1'b0;

    // Single burst 0x01..0x08 with out_ready high: exact cycle timing.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) push(DW'(i));
    step(); step();
    for (int k = 0; k < 12; k++) begin
      start = (k == 0);
      step();
      chk("seqA_valid", 32'(s_valid), 32'(k >= 2 && k <= 9));
      chk("seqA_last", 32'(s_last), 32'(k == 9));
      chk("seqA_done", 32'(s_done), 32'(k == 10));
    end
    chk("seqA_count", 32'(fifo_pop_count), 0);

    // Five words: no burst. Three more: burst proceeds.
    flush();
    for (int i = 0; i < 5; i++) push(DW'(16'h0050 + i));
    start = 1'b1;
    repeat (4) step();
    start = 1'b0;
    chk("five_busy", 32'(busy), 0);
    chk("five_ready", 32'(burst_ready), 0);
    chk("five_count", 32'(fifo_pop_count), 5);
    for (int i = 5; i < 8; i++) push(DW'(16'h0050 + i));
    step(); step();
    chk("eight_ready", 32'(burst_ready), 1);
    start = 1'b1; step(); start = 1'b0;
    wait_done(40);
    chk("eight_count", 32'(fifo_pop_count), 0);

    // Table of preload levels and backpressure patterns.
    foreach (vecs[v]) begin
      flush();
      for (int i = 0; i < int'(vecs[v].preload); i++) push(DW'($urandom));
      out_ready = 1'b1;
      step();
      n0 = n_out;
      start = 1'b1; step(); start = 1'b0;
      pat = vecs[v].ready_pat;
      for (int k = 0; k < 60; k++) begin
        out_ready = pat[k % 4];
        step();
      end
      chk("vec_words", n_out - n0, vecs[v].exp_accept ? BL : 0);
      chk("vec_count", 32'(fifo_pop_count),
          vecs[v].preload - (vecs[v].exp_accept ? BL : 0));
      chk("vec_idle", 32'(busy), 0);
    end

    // 16 words, out_ready 1,0,0,1..., then back-to-back start on burst_done.
    flush();
    for (int i = 1; i <= 16; i++) push(DW'(16'h0A00 + i));
    out_ready = 1'b1;
    step();
    n0 = n_out;
    start = 1'b1; step(); start = 1'b0;
    for (int k = 0; k < 60 && !burst_done; k++) begin
      out_ready = (k % 4 == 0) || (k % 4 == 3);
      step();
    end
    chk("toggle_done", 32'(burst_done), 1);
    chk("toggle_words", n_out - n0, 8);
    chk("toggle_count", 32'(fifo_pop_count), 8);
    chk("toggle_ready", 32'(burst_ready), 1);
    start = 1'b1; step(); start = 1'b0;
    chk("b2b_busy", 32'(busy), 1);
    out_ready = 1'b1;
    wait_done(40);
    chk("b2b_words", n_out - n0, 16);
    chk("b2b_count", 32'(fifo_pop_count), 0);

    // Reset after three transfers of a burst.
    flush();
    for (int i = 1; i <= 16; i++) push(DW'(16'h0B00 + i));
    step();
    n0 = n_out;
    start = 1'b1; step(); start = 1'b0;
    for (int k = 0; k < 20 && (n_out - n0) < 3; k++) step();
    chk("pre_reset_words", n_out - n0, 3);
    do_reset();
    c0 = 32'(fifo_pop_count);
    repeat (6) step();
    chk("post_reset_nopop", 32'(fifo_pop_count), c0);
    start = 1'b1; step(); start = 1'b0;
    wait_done(40);

    // Randomised traffic.
    for (int k = 0; k < 1500; k++) begin
      if ((wr - rd) < 16 && $urandom_range(1, 0) == 1) push(DW'($urandom));
      out_ready = ($urandom_range(3, 0) != 0);
      start     = ($urandom_range(5, 0) == 0);
      if ($urandom_range(499, 0) == 0) do_reset();
      step();
    end
    start = 1'b0; out_ready = 1'b1;
    repeat (40) step();
    chk("final_idle", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
